// File: rtl/notes_key_encoder.sv
// Note-key input path: synchronise and debounce eight one-hot keys, priority-encode
// each new press into the playback note index and queue it on a valid/ready stream.

module notes_key_lane #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic level
);
   localparam int CW = 8;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         // A single agreeing sample restarts the stability count.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module notes_key_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    key_in,
   output logic                          note_valid,
   input  logic                          note_ready,
   output logic [2:0]                    note_code,
   output logic                          note_multi,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          overflow_clr
);
   localparam int NUM_LANES = 8;
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;

   typedef struct packed {
      logic       multi;
      logic [2:0] code;
   } entry_t;

   logic [NUM_LANES-1:0] level, level_q, press;
   logic [2:0]           enc_code;
   logic                 enc_multi;
   logic                 push_req, push, pop, full;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   entry_t               mem [FIFO_DEPTH];
   entry_t               head;

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         notes_key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .key   (key_in[g]),
            .level (level[g])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) level_q <= '0;
      else     level_q <= level;
   end

   // Only rising debounced levels are presses; releases are ignored.
   assign press = level & ~level_q;

   always_comb begin
      enc_code = 3'd0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (press[i]) enc_code = 3'(i);
      end
   end

   assign enc_multi = (press & (press - 8'd1)) != '0;
   assign push_req  = |press;
   assign full      = (count == CW'(FIFO_DEPTH));
   assign pop       = note_valid & note_ready;
   assign push      = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{multi: enc_multi, code: enc_code};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A dropped press wins over a same-cycle clear.
         if (push_req && full && !pop) overflow <= 1'b1;
         else if (overflow_clr)        overflow <= 1'b0;
      end
   end

   assign head       = mem[rd_ptr];
   assign note_valid = (count != '0);
   assign note_code  = note_valid ? head.code  : 3'd0;
   assign note_multi = note_valid ? head.multi : 1'b0;
   assign fifo_count = count;
endmodule

// File: tb/tb_notes_key_encoder.sv
// Bench for notes_key_encoder: directed scenarios plus random key traffic, all
// compared each cycle against a queue-based behavioural model.

module tb_notes_key_encoder;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key_in = 8'h00;
   logic       note_ready = 1'b0;
   logic       overflow_clr = 1'b0;
   logic       note_valid, note_multi, overflow;
   logic [2:0] note_code;
   logic [2:0] fifo_count;

   always #5 clk = ~clk;

   notes_key_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .note_valid   (note_valid),
      .note_ready   (note_ready),
      .note_code    (note_code),
      .note_multi   (note_multi),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raw key history, window of debounce samples, note queue.
   logic [7:0] hist_q[$];
   logic [7:0] used_q[$];
   logic [3:0] m_fifo[$];
   logic [7:0] m_lvl = 8'h00;
   logic [7:0] m_prev = 8'h00;
   logic       m_ovf = 1'b0;

   task automatic model_step();
      logic [7:0] ev, samp;
      logic       pop, full, drop, all_diff;
      int         lo;
      if (rst) begin
         hist_q.delete();
         used_q.delete();
         m_fifo.delete();
         m_lvl  = 8'h00;
         m_prev = 8'h00;
         m_ovf  = 1'b0;
         return;
      end
      ev     = m_lvl & ~m_prev;
      m_prev = m_lvl;
      hist_q.push_back(key_in);
      samp = (hist_q.size() >= 3) ? hist_q[hist_q.size() - 3] : 8'h00;
      if (hist_q.size() > 3) void'(hist_q.pop_front());
      used_q.push_back(samp);
      if (used_q.size() > D) void'(used_q.pop_front());
      if (used_q.size() == D) begin
         for (int i = 0; i < 8; i++) begin
            all_diff = 1'b1;
            foreach (used_q[j]) if (used_q[j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) m_lvl[i] = ~m_lvl[i];
         end
      end
      pop  = (m_fifo.size() != 0) && note_ready;
      full = (m_fifo.size() == DEPTH);
      drop = 1'b0;
      if (pop) void'(m_fifo.pop_front());
      if (ev != 8'h00) begin
         lo = 0;
         for (int i = 7; i >= 0; i--) if (ev[i]) lo = i;
         if (!full || pop) m_fifo.push_back({($countones(ev) > 1), 3'(lo)});
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
   endtask

   task automatic check_outputs();
      logic [3:0] head;
      head = (m_fifo.size() != 0) ? m_fifo[0] : 4'h0;
      chk("note_valid", note_valid, m_fifo.size() != 0);
      chk("note_code", note_code, head[2:0]);
      chk("note_multi", note_multi, head[3]);
      chk("fifo_count", fifo_count, m_fifo.size());
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input int k, input int hi, input int lo);
      key_in = 8'h01 << k;
      run(hi);
      key_in = 8'h00;
      run(lo);
   endtask

   initial begin
      int hold;
      // reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_valid", note_valid, 1'b0);
      chk("rst_count", fifo_count, 3'd0);
      chk("rst_ovf", overflow, 1'b0);

      // 1: single key latency
      note_ready = 1'b1;
      key_in = 8'h04;
      run(6);
      chk("t1_early", note_valid, 1'b0);
      tick();
      chk("t1_valid", note_valid, 1'b1);
      chk("t1_code", note_code, 3'd2);
      chk("t1_multi", note_multi, 1'b0);
      tick();
      chk("t1_once", note_valid, 1'b0);
      chk("t1_count", fifo_count, 3'd0);
      run(12);
      key_in = 8'h00;
      run(10);

      // 2: short pulse rejected, bounced press counted once
      note_ready = 1'b0;
      key_in = 8'h20; run(3);
      key_in = 8'h00; run(12);
      chk("t2_pulse", fifo_count, 3'd0);
      key_in = 8'h20; run(3);
      key_in = 8'h00; run(1);
      key_in = 8'h20; run(3);
      key_in = 8'h00; run(1);
      key_in = 8'h20; run(10);
      chk("t2_count", fifo_count, 3'd1);
      chk("t2_code", note_code, 3'd5);
      key_in = 8'h00; run(8);
      note_ready = 1'b1; run(3);

      // 3: simultaneous presses
      note_ready = 1'b0;
      key_in = 8'h48; run(10);
      chk("t3_count", fifo_count, 3'd1);
      chk("t3_code", note_code, 3'd3);
      chk("t3_multi", note_multi, 1'b1);
      key_in = 8'h00; run(8);
      note_ready = 1'b1; run(3);

      // 4: overflow and drain order
      note_ready = 1'b0;
      for (int k = 0; k < 5; k++) press(k, 6, 6);
      run(4);
      chk("t4_count", fifo_count, 3'd4);
      chk("t4_ovf", overflow, 1'b1);
      chk("t4_head0", note_code, 3'd0);
      note_ready = 1'b1;
      tick(); chk("t4_head1", note_code, 3'd1);
      tick(); chk("t4_head2", note_code, 3'd2);
      tick(); chk("t4_head3", note_code, 3'd3);
      tick(); chk("t4_empty", note_valid, 1'b0);
      chk("t4_ovf_held", overflow, 1'b1);
      overflow_clr = 1'b1; tick();
      overflow_clr = 1'b0;
      chk("t4_ovf_clr", overflow, 1'b0);

      // 5: full with push coinciding with pop
      note_ready = 1'b0;
      for (int k = 0; k < 4; k++) press(k, 6, 6);
      chk("t5_full", fifo_count, 3'd4);
      key_in = 8'h20; run(6);
      note_ready = 1'b1; tick();
      note_ready = 1'b0;
      chk("t5_count", fifo_count, 3'd4);
      chk("t5_ovf", overflow, 1'b0);
      chk("t5_head1", note_code, 3'd1);
      key_in = 8'h00;
      note_ready = 1'b1;
      tick(); chk("t5_head2", note_code, 3'd2);
      tick(); chk("t5_head3", note_code, 3'd3);
      tick(); chk("t5_head5", note_code, 3'd5);
      tick(); chk("t5_empty", note_valid, 1'b0);
      run(8);

      // 6: reset discards queue, held key re-pressed
      note_ready = 1'b0;
      press(0, 6, 6);
      key_in = 8'h80; run(10);
      chk("t6_queued", fifo_count, 3'd2);
      rst = 1'b1; tick();
      rst = 1'b0;
      chk("t6_valid", note_valid, 1'b0);
      chk("t6_count", fifo_count, 3'd0);
      chk("t6_code", note_code, 3'd0);
      note_ready = 1'b1;
      run(6);
      chk("t6_early", note_valid, 1'b0);
      tick();
      chk("t6_valid7", note_valid, 1'b1);
      chk("t6_code7", note_code, 3'd7);
      tick();
      chk("t6_once", note_valid, 1'b0);
      run(10);
      chk("t6_none", fifo_count, 3'd0);
      key_in = 8'h00; run(10);

      // random traffic against the model
      for (int c = 0; c < 2000; c += hold) begin
         hold = $urandom_range(1, 9);
         case ($urandom_range(0, 3))
            0:       key_in = 8'h00;
            3:       key_in = 8'($urandom);
            default: key_in = 8'h01 << $urandom_range(0, 7);
         endcase
         for (int h = 0; h < hold; h++) begin
            note_ready   = ($urandom_range(0, 9) < 6);
            overflow_clr = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick();
         end
      end
      rst = 1'b0;
      overflow_clr = 1'b0;
      run(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
